// File: rtl/shared_adder_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder between two requesters.
// Each request selects signed or unsigned addition; results carry overflow and owner ID.
module shared_adder_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_signed,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_signed,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   res_sum,
  output logic             res_ovf,
  output logic             res_id,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  function automatic logic [WIDTH:0] add_ext(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             sgn);
    logic [WIDTH:0] ea;
    logic [WIDTH:0] eb;
    ea = {sgn & a[WIDTH-1], a};
    eb = {sgn & b[WIDTH-1], b};
    return ea + eb;
  endfunction

  // Overflow means the low WIDTH bits alone misrepresent the exact sum.
  function automatic logic ovf_of(input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b,
                                  input logic             sgn,
                                  input logic [WIDTH:0]   sum);
    if (sgn) return (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    return sum[WIDTH];
  endfunction

  logic [1:0]       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d, id_q, id_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH:0]   res_sum_q, res_sum_d;
  logic             res_ovf_q, res_ovf_d, res_id_q, res_id_d;
  logic             grant0, grant1;
  logic [WIDTH:0]   sum_w;

  assign sum_w  = add_ext(a_q, b_q, sgn_q);
  assign grant1 = req1_valid && (!req0_valid || ptr_q);
  assign grant0 = req0_valid && !grant1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    sgn_d       = sgn_q;
    id_d        = id_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_ovf_d   = res_ovf_q;
    res_id_d    = res_id_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          req0_ready = grant0;
          req1_ready = grant1;
          a_d        = grant1 ? req1_a : req0_a;
          b_d        = grant1 ? req1_b : req0_b;
          sgn_d      = grant1 ? req1_signed : req0_signed;
          id_d       = grant1;
          state_d    = ADD;
        end
      end
      ADD: begin
        res_sum_d   = sum_w;
        res_ovf_d   = ovf_of(a_q, b_q, sgn_q, sum_w);
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        // Pointer moves only on the result handshake, toward the requester not just served.
        if (res_ready) begin
          res_valid_d = 1'b0;
          ptr_d       = ~res_id_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 1'b0;
      id_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_ovf_q   <= 1'b0;
      res_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sgn_q       <= sgn_d;
      id_q        <= id_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_ovf_q   <= res_ovf_d;
      res_id_q    <= res_id_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_ovf   = res_ovf_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Bench for shared_adder_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_shared_adder_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_signed;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_signed;
  logic [W-1:0] req1_a, req1_b;
  logic         res_valid, res_ready, res_ovf, res_id, busy;
  logic [W:0]   res_sum;

  int checks = 0;
  int failures = 0;

  shared_adder_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_signed(req0_signed),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_signed(req1_signed),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_ovf(res_ovf), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference arithmetic from plain integer values of the operands.
  function automatic void ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input bit s, output logic [W:0] sum, output bit ovf);
    int ia, ib, ex;
    ia = int'(a);
    ib = int'(b);
    if (s) begin
      if (a[W-1]) ia -= (1 << W);
      if (b[W-1]) ib -= (1 << W);
    end
    ex  = ia + ib;
    sum = ex[W:0];
    if (s) ovf = (ex > (1 << (W-1)) - 1) || (ex < -(1 << (W-1)));
    else   ovf = (ex > (1 << W) - 1);
  endfunction

  task automatic reset_dut();
    rst_n = 1'b0;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_signed = 0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_signed = 0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issues one request alone and waits for its result (res_ready is left to the caller).
  task automatic do_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit s, output bit rdy, output int lat,
                       output logic [W:0] sum, output logic ovf, output logic rid);
    @(negedge clk);
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_signed = s; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_signed = s; end
    #1 rdy = id ? req1_ready : req0_ready;
    @(posedge clk);
    #1 req0_valid = 0; req1_valid = 0;
    lat = 0;
    while (lat < 20 && res_valid !== 1'b1) begin
      @(negedge clk);
      lat++;
    end
    sum = res_sum; ovf = res_ovf; rid = res_id;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (res_sum !== '0 || res_ovf !== 1'b0 || res_id !== 1'b0)
      begin failures++; $display("FAIL rst_result got=%b/%b/%b exp=0/0/0", res_sum, res_ovf, res_id); end
    // Drive requester 1 into HOLD, then pull reset between clock edges.
    res_ready = 1'b0;
    @(negedge clk);
    req1_valid = 1; req1_a = 4'd5; req1_b = 4'd6; req1_signed = 0;
    @(posedge clk);
    #1 req1_valid = 0;
    repeat (2) @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_id !== 1'b1 || res_sum !== 5'd11)
      begin failures++; $display("FAIL pre_rst_hold got=%b/%b/%0d exp=1/1/11", res_valid, res_id, res_sum); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0)
      begin failures++; $display("FAIL async_rst_ctl got=%b/%b exp=0/0", res_valid, busy); end
    checks++; if (res_sum !== '0 || res_id !== 1'b0)
      begin failures++; $display("FAIL async_rst_data got=%0d/%b exp=0/0", res_sum, res_id); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || res_valid !== 1'b0)
      begin failures++; $display("FAIL idle_after_rst got=%b%b%b%b exp=0000", busy, req0_ready, req1_ready, res_valid); end
  endtask

  task automatic test_unsigned();
    bit rdy; int lat; logic [W:0] sum; logic ovf, rid;
    res_ready = 1'b1;
    do_op(1'b0, 4'd7, 4'd9, 1'b0, rdy, lat, sum, ovf, rid);
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL u_ready got=%b exp=1", rdy); end
    checks++; if (lat != 2) begin failures++; $display("FAIL u_latency got=%0d exp=2", lat); end
    checks++; if (sum !== 5'b10000 || ovf !== 1'b1 || rid !== 1'b0)
      begin failures++; $display("FAIL u_7p9 got=%b/%b/%b exp=10000/1/0", sum, ovf, rid); end
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0)
      begin failures++; $display("FAIL u_release got=%b/%b exp=0/0", res_valid, busy); end
  endtask

  task automatic test_signed();
    logic [W-1:0] ta [3] = '{4'b1100, 4'd7, 4'b1100};
    logic [W-1:0] tb [3] = '{4'b1100, 4'd1, 4'd3};
    logic [W:0]   ts [3] = '{5'b11000, 5'b01000, 5'b11111};
    logic         to [3] = '{1'b0, 1'b1, 1'b0};
    bit rdy; int lat; logic [W:0] sum; logic ovf, rid;
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b1, ta[i], tb[i], 1'b1, rdy, lat, sum, ovf, rid);
      checks++; if (rdy !== 1'b1 || lat != 2)
        begin failures++; $display("FAIL s_hs%0d got=%b/%0d exp=1/2", i, rdy, lat); end
      checks++; if (sum !== ts[i] || ovf !== to[i] || rid !== 1'b1)
        begin failures++; $display("FAIL s_case%0d got=%b/%b/%b exp=%b/%b/1", i, sum, ovf, rid, ts[i], to[i]); end
    end
  endtask

  task automatic test_mixed_mode();
    bit rdy; int lat; logic [W:0] sum; logic ovf, rid;
    res_ready = 1'b1;
    do_op(1'b0, 4'b1100, 4'd3, 1'b0, rdy, lat, sum, ovf, rid);
    checks++; if (sum !== 5'b01111 || ovf !== 1'b0)
      begin failures++; $display("FAIL mix_unsigned got=%b/%b exp=01111/0", sum, ovf); end
    do_op(1'b0, 4'b1100, 4'd3, 1'b1, rdy, lat, sum, ovf, rid);
    checks++; if (sum !== 5'b11111 || ovf !== 1'b0)
      begin failures++; $display("FAIL mix_signed got=%b/%b exp=11111/0", sum, ovf); end
  endtask

  task automatic test_arbitration();
    int g_id [$]; int g_cyc [$]; int r_id [$];
    reset_dut();
    res_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1; req0_a = 4'd1; req0_b = 4'd2; req0_signed = 0;
    req1_valid = 1; req1_a = 4'd3; req1_b = 4'd4; req1_signed = 0;
    for (int c = 0; c < 30 && (g_id.size() < 4 || r_id.size() < 4); c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (req0_ready && req1_ready) begin
        failures++; checks++; $display("FAIL arb_dual_grant cycle=%0d", c);
      end
      if (req0_ready || req1_ready) begin g_id.push_back(req1_ready); g_cyc.push_back(c); end
      if (res_valid) r_id.push_back(res_id);
    end
    req0_valid = 0; req1_valid = 0;
    checks++; if (g_id.size() < 4 || r_id.size() < 4)
      begin failures++; $display("FAIL arb_count got=%0d/%0d exp=4/4", g_id.size(), r_id.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (g_id[i] != (i % 2) || r_id[i] != (i % 2))
          begin failures++; $display("FAIL arb_order%0d got=%0d/%0d exp=%0d", i, g_id[i], r_id[i], i % 2); end
      end
      for (int i = 1; i < 4; i++) begin
        checks++; if (g_cyc[i] - g_cyc[i-1] != 3)
          begin failures++; $display("FAIL arb_spacing%0d got=%0d exp=3", i, g_cyc[i] - g_cyc[i-1]); end
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [W:0] snap;
    res_ready = 1'b0;
    @(negedge clk);
    req1_valid = 1; req1_a = 4'd2; req1_b = 4'd3; req1_signed = 0;
    @(posedge clk);
    #1 req1_valid = 0;
    repeat (2) @(negedge clk);
    req0_valid = 1; req0_a = 4'd1; req0_b = 4'd1; req0_signed = 0;
    #1 snap = res_sum;
    checks++; if (snap !== 5'd5) begin failures++; $display("FAIL bp_sum got=%0d exp=5", snap); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (res_valid !== 1'b1 || res_sum !== snap || req0_ready !== 1'b0)
        begin failures++; $display("FAIL bp_stall%0d got=%b/%0d/%b exp=1/%0d/0", i, res_valid, res_sum, req0_ready, snap); end
      @(negedge clk);
      #1;
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (req0_ready !== 1'b1 || res_valid !== 1'b0)
      begin failures++; $display("FAIL bp_regrant got=%b/%b exp=1/0", req0_ready, res_valid); end
    @(posedge clk);
    #1 req0_valid = 0;
    repeat (2) @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_sum !== 5'd2 || res_id !== 1'b0)
      begin failures++; $display("FAIL bp_next got=%b/%0d/%b exp=1/2/0", res_valid, res_sum, res_id); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    bit v [2]; logic [W-1:0] ra [2]; logic [W-1:0] rb [2]; bit rs [2]; bit taken [2];
    bit m_busy, m_ptr, exp_id, exp_valid, eg0, eg1, src;
    int m_age, n_res;
    logic [W:0] exp_sum; bit exp_ovf;
    reset_dut();
    m_busy = 0; m_ptr = 0; m_age = 0; n_res = 0; exp_id = 0; exp_sum = '0; exp_ovf = 0;
    v = '{0, 0}; taken = '{1, 1};
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (!v[r] || taken[r]) begin
          v[r] = ($urandom % 2) == 1;
          ra[r] = W'($urandom); rb[r] = W'($urandom); rs[r] = ($urandom % 2) == 1;
        end
        taken[r] = 0;
      end
      req0_valid = v[0]; req0_a = ra[0]; req0_b = rb[0]; req0_signed = rs[0];
      req1_valid = v[1]; req1_a = ra[1]; req1_b = rb[1]; req1_signed = rs[1];
      res_ready = ($urandom % 4) != 0;
      #1;
      exp_valid = m_busy && m_age >= 2;
      checks++; if (res_valid !== exp_valid)
        begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, res_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (res_sum !== exp_sum || res_ovf !== exp_ovf || res_id !== exp_id)
          begin failures++; $display("FAIL rnd_result c=%0d got=%b/%b/%b exp=%b/%b/%b", c, res_sum, res_ovf, res_id, exp_sum, exp_ovf, exp_id); end
      end
      checks++; if (busy !== m_busy)
        begin failures++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, m_busy); end
      eg0 = 0; eg1 = 0;
      if (!m_busy) begin
        if (v[0] && v[1]) begin eg0 = !m_ptr; eg1 = m_ptr; end
        else begin eg0 = v[0]; eg1 = v[1]; end
      end
      checks++; if (req0_ready !== eg0 || req1_ready !== eg1)
        begin failures++; $display("FAIL rnd_grant c=%0d got=%b%b exp=%b%b", c, req1_ready, req0_ready, eg1, eg0); end
      if (eg0 || eg1) begin
        src = eg1;
        taken[src] = 1;
        ref_add(ra[src], rb[src], rs[src], exp_sum, exp_ovf);
        exp_id = src; m_busy = 1; m_age = 1;
      end else if (m_busy) begin
        if (exp_valid && res_ready) begin m_busy = 0; m_ptr = !exp_id; n_res++; end
        else m_age++;
      end
    end
    checks++; if (n_res < 20)
      begin failures++; $display("FAIL rnd_progress got=%0d exp>=20", n_res); end
    req0_valid = 0; req1_valid = 0; res_ready = 1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_mixed_mode();
    test_arbitration();
    test_backpressure();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
